gol_neighbour_accumulator: RTL and testbench

// Sequential neighbour counter plus Conway rule stage for the game-of-life datapath.

---
 rtl/gol_neighbour_accumulator_pkg.sv | 21 ++
 rtl/gol_neighbour_accumulator_adder_n.sv | 20 ++
 rtl/gol_neighbour_accumulator.sv | 134 +++++++++++++
 tb/tb_gol_neighbour_accumulator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gol_neighbour_accumulator_pkg.sv
// Shared types and constants for the game-of-life neighbour accumulator.
//   acc_state_t : FSM encoding (idle / counting / result held)
//   acc_dbg_t   : debug view of the accumulator (FSM state + adder carry)
//   BIRTH_COUNT / SURVIVE_COUNT : Conway rule thresholds
package gol_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } acc_state_t;

  typedef struct packed {
    acc_state_t state;
    logic       carry;
  } acc_dbg_t;

  localparam int BIRTH_COUNT   = 3;
  localparam int SURVIVE_COUNT = 2;

endpackage

// File: rtl/gol_neighbour_accumulator_adder_n.sv
// N-bit ripple adder used for the accumulate step.
//   a, b   : N-bit operands
//   c_in   : carry in
//   sum    : N-bit result
//   c_out  : carry out of the top bit
module adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  always_comb begin
    {c_out, sum} = (N+1)'(a) + (N+1)'(b) + (N+1)'(c_in);
  end

endmodule

// File: rtl/gol_neighbour_accumulator.sv
// Serial neighbour counter plus Conway rule stage.
//   clk, rst          : clock, synchronous active-low reset
//   i_valid / i_ready : input handshake; neighbours and state_in captured on accept
//   neighbours        : NEIGHBOURS live bits for one cell
//   state_in          : current cell state
//   o_valid / o_ready : output handshake
//   count             : number of live neighbours of the captured cell
//   next_state        : Conway next state of the captured cell
//   dbg               : FSM state and adder carry, for checkers
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high. Once o_valid rises, count and next_state stay stable until o_ready is
// seen; i_ready is high only in S_IDLE, so i_ready and o_valid are never high
// together.
module gol_neighbour_accumulator
  import gol_pkg::*;
#(
  parameter int N          = 4,
  parameter int NEIGHBOURS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [NEIGHBOURS-1:0] neighbours,
  input  logic                  state_in,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [N-1:0]          count,
  output logic                  next_state,
  output acc_dbg_t              dbg
);

  if (NEIGHBOURS < 1) begin : g_bad_neighbours
    $error("gol_neighbour_accumulator: NEIGHBOURS must be >= 1");
  end
  if (N < $clog2(NEIGHBOURS + 1)) begin : g_bad_width
    $error("gol_neighbour_accumulator: N too small to hold NEIGHBOURS");
  end

  // idx must index 0..NEIGHBOURS-1; keep at least one bit when NEIGHBOURS==1.
  localparam int IW = (NEIGHBOURS > 1) ? $clog2(NEIGHBOURS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NEIGHBOURS - 1);

  acc_state_t            state_q, state_d;
  logic [N-1:0]          acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NEIGHBOURS-1:0] shreg_q, shreg_d;
  logic                  cell_q, cell_d;

  logic [N-1:0]          add_sum;
  logic                  add_c_out;

  adder_n #(.N(N)) u_adder (
    .a     (acc_q),
    .b     (N'(shreg_q[0])),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_c_out)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      cell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      cell_q  <= cell_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid)          state_d = S_COUNT;
      S_COUNT: if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  if (o_ready)          state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, shift-and-add while counting.
  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cell_d  = cell_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          shreg_d = neighbours;
          cell_d  = state_in;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      S_COUNT: begin
        acc_d   = add_sum;
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    i_ready    = (state_q == S_IDLE);
    o_valid    = (state_q == S_DONE);
    count      = acc_q;
    next_state = (acc_q == N'(BIRTH_COUNT)) ||
                 (cell_q && (acc_q == N'(SURVIVE_COUNT)));
    dbg.state  = state_q;
    dbg.carry  = add_c_out;
  end

`ifdef SIMULATION
  // The accumulator is sized to hold NEIGHBOURS, so the adder can never carry.
  always @(posedge clk) begin
    if (rst && state_q == S_COUNT) begin
      assert (!add_c_out) else $error("adder carry out while counting");
    end
  end
`endif

endmodule

// File: tb/tb_gol_neighbour_accumulator.sv
module tb_gol_neighbour_accumulator;
  import gol_pkg::*;

  localparam int N  = 4;
  localparam int NB = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [NB-1:0] neighbours = '0;
  logic          state_in = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [N-1:0]  count;
  logic          next_state;
  acc_dbg_t      dbg;

  always #5 clk = ~clk;

  gol_neighbour_accumulator #(.N(N), .NEIGHBOURS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .neighbours (neighbours),
    .state_in   (state_in),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .count      (count),
    .next_state (next_state),
    .dbg        (dbg)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard: {count, next_state} for each accepted cell.
  logic [4:0] exp_q[$];

  // Reference: Conway rule straight from the live-neighbour population count.
  function automatic logic [4:0] model(input logic [NB-1:0] nb, input logic st);
    int  c;
    logic nx;
    c  = $countones(nb);
    nx = (c == 3) || (st && (c == 2));
    return {c[3:0], nx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Offers one cell, follows it through counting (with junk on the input side
  // that must be ignored), holds o_ready low for 'stall' cycles, then drains.
  task automatic run_cell(input logic [NB-1:0] nb, input logic st, input int stall);
    int w;
    int k;
    logic [4:0] exp;
    w = 0;
    i_valid    = 1'b1;
    neighbours = nb;
    state_in   = st;
    while (!i_ready && w < 20) begin
      step();
      w++;
    end
    check("accept_ready", 32'(i_ready), 32'd1);
    if (!i_ready) begin
      i_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(nb, st));
    step();  // accept edge
    k = 0;
    while (!o_valid && k < 40) begin
      check("busy_i_ready", 32'(i_ready), 32'd0);
      i_valid    = 1'($urandom);
      neighbours = NB'($urandom);
      state_in   = 1'($urandom);
      step();
      k++;
    end
    i_valid = 1'b0;
    check("latency", 32'(k), 32'(NB));
    check("o_valid_up", 32'(o_valid), 32'd1);
    if (!o_valid) return;
    exp = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      check("stall_count", 32'(count), 32'(exp[4:1]));
      check("stall_next", 32'(next_state), 32'(exp[0]));
      check("stall_i_ready", 32'(i_ready), 32'd0);
      step();
      check("stall_o_valid", 32'(o_valid), 32'd1);
    end
    o_ready = 1'b1;
    check("count", 32'(count), 32'(exp[4:1]));
    check("next_state", 32'(next_state), 32'(exp[0]));
    check("done_i_ready", 32'(i_ready), 32'd0);
    step();
    o_ready = 1'b0;
    check("drain_o_valid", 32'(o_valid), 32'd0);
    check("drain_i_ready", 32'(i_ready), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    step();
    step();
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(S_IDLE));
    rst = 1'b1;
    step();

    // Empty, birth, survive, lonely-with-two-dead, overcrowding.
    run_cell(8'h00, 1'b0, 0);
    run_cell(8'h07, 1'b0, 0);
    run_cell(8'h11, 1'b1, 0);
    run_cell(8'h11, 1'b0, 0);
    run_cell(8'hFF, 1'b1, 0);

    // Backpressure held for 5 cycles.
    run_cell(8'h0B, 1'b1, 5);

    // Reset 4 cycles into counting drops the cell.
    i_valid    = 1'b1;
    neighbours = 8'hFF;
    state_in   = 1'b1;
    step();
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_o_valid", 32'(o_valid), 32'd0);
    check("mid_rst_i_ready", 32'(i_ready), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_state", 32'(dbg.state), 32'(S_IDLE));
    for (int i = 0; i < NB + 2; i++) begin
      step();
      check("dropped_no_o_valid", 32'(o_valid), 32'd0);
    end
    run_cell(8'h80, 1'b0, 0);

    // Every pattern for both cell states with random output stalls.
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 256; p++) begin
        run_cell(NB'(p), 1'(s), $urandom_range(0, 3));
      end
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
